exc_ctrl: RTL and testbench

Exception and CSR controller for the five-stage LoongArch pipeline. It owns the privileged CSRs (CRMD, PRMD, ECFG, ESTAT, ERA, EENTRY, SAVE0-3, TCFG, TVAL, TICLR) and serves the WB stage's CSR read/write port. It sequences exception entry and ERTN return into a one-cycle flush plus PC redirect for IF, runs the stable timer, and raises the interrupt-pending flag consumed by ID.

---
 rtl/csr_defs.sv | 53 +++++
 rtl/exc_ctrl_stable_timer.sv | 56 +++++
 rtl/exc_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_exc_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_defs.sv
// Shared CSR numbers, field positions, write masks and exception codes
// for the LoongArch exception/CSR controller.
package csr_defs;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam int CRMD_IE        = 2;
    localparam int TCFG_EN        = 0;
    localparam int TCFG_PERIODIC  = 1;
    localparam int ESTAT_IS_TI    = 11;
    localparam int ESTAT_ECODE_LO = 16;
    localparam int ESTAT_ESUB_LO  = 22;

    localparam logic [31:0] CRMD_WMASK   = 32'h0000_000F;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Masked CSR write limited to the register's writable fields.
    function automatic logic [31:0] csr_merge(
        input logic [31:0] old,
        input logic [31:0] wmask,
        input logic [31:0] wvalue,
        input logic [31:0] fmask
    );
        logic [31:0] m;
        m = wmask & fmask;
        return (old & ~m) | (wvalue & m);
    endfunction

endpackage

// File: rtl/exc_ctrl_stable_timer.sv
// Stable timer: holds TCFG and TVAL, emits a one-cycle expiry pulse.
// Ports: i_we/i_wmask/i_wvalue TCFG write; o_tcfg/o_tval read data; o_expire.
module stable_timer #(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_we,
    input  logic [31:0] i_wmask,
    input  logic [31:0] i_wvalue,
    output logic [31:0] o_tcfg,
    output logic [31:0] o_tval,
    output logic        o_expire
);
    import csr_defs::*;

    logic                 r_en;
    logic                 r_per;
    logic [TIMER_W-3:0]   r_init;
    logic [TIMER_W-1:0]   r_tval;
    logic [31:0]          w_old;
    logic [31:0]          w_new;

    assign w_old  = 32'({r_init, r_per, r_en});
    assign w_new  = csr_merge(w_old, i_wmask, i_wvalue, FULL_WMASK);
    assign o_tcfg = w_old;
    assign o_tval = 32'(r_tval);

    // A TCFG write in the same cycle as the 1->0 step wins over expiry.
    assign o_expire = ~i_we & r_en & (r_tval == TIMER_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_en   <= 1'b0;
            r_per  <= 1'b0;
            r_init <= '0;
            r_tval <= '1;
        end else if (i_we) begin
            r_en   <= w_new[TCFG_EN];
            r_per  <= w_new[TCFG_PERIODIC];
            r_init <= w_new[TIMER_W-1:2];
            r_tval <= {w_new[TIMER_W-1:2], 2'b00};
        end else if (r_en) begin
            if (r_tval != '0) begin
                r_tval <= r_tval - TIMER_W'(1);
            end else if (r_per) begin
                r_tval <= {r_init, 2'b00};
            end else begin
                // One-shot: park at all-ones and stop.
                r_tval <= '1;
                r_en   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/CSR controller: privileged CSRs, exception entry / ERTN flush
// with PC redirect, stable timer and interrupt-pending flag for ID.
module exc_ctrl #(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic        ertn_flush,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [7:0]  hw_int,
    output logic        has_int,
    output logic        flush,
    output logic [31:0] redirect_pc
);
    import csr_defs::*;

    logic [0:0]  r_state;
    logic [31:0] r_crmd;
    logic [31:0] r_prmd;
    logic [31:0] r_ecfg;
    logic [1:0]  r_is_sw;
    logic [7:0]  r_is_hw;
    logic        r_is_ti;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esub;
    logic [31:0] r_era;
    logic [31:0] r_eentry;
    logic [31:0] r_save [4];

    logic        w_idle;
    logic        w_exc;
    logic        w_ertn;
    logic        w_wr;
    logic        w_tcfg_we;
    logic        w_ticlr;
    logic        w_expire;
    logic [31:0] w_tcfg;
    logic [31:0] w_tval;
    logic [31:0] w_estat;
    logic [31:0] w_rdata;

    // Wrong-path events in FLUSH are dropped; exceptions/ERTN block writes.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_exc     = w_idle & wb_ex;
    assign w_ertn    = w_idle & ertn_flush & ~wb_ex;
    assign w_wr      = w_idle & csr_we & ~wb_ex & ~ertn_flush;
    assign w_tcfg_we = w_wr & (csr_num == CSR_TCFG);
    assign w_ticlr   = w_wr & (csr_num == CSR_TICLR)
                     & csr_wmask[0] & csr_wvalue[0];

    assign flush       = w_exc | w_ertn;
    assign redirect_pc = wb_ex ? r_eentry : r_era;

    assign w_estat = {1'b0, r_esub, r_ecode, 4'b0000,
                      r_is_ti, 1'b0, r_is_hw, r_is_sw};

    assign has_int = r_crmd[CRMD_IE]
                   & (|(w_estat[12:0] & r_ecfg[12:0]));

    stable_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .i_we     (w_tcfg_we),
        .i_wmask  (csr_wmask),
        .i_wvalue (csr_wvalue),
        .o_tcfg   (w_tcfg),
        .o_tval   (w_tval),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else if (w_exc | w_ertn) begin
            r_state <= ST_FLUSH;
        end else begin
            r_state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_crmd <= 32'h0000_0008;
            r_prmd <= '0;
        end else if (w_exc) begin
            r_prmd[2:0] <= r_crmd[2:0];
            r_crmd[2:0] <= 3'b000;
        end else if (w_ertn) begin
            r_crmd[2:0] <= r_prmd[2:0];
        end else if (w_wr && csr_num == CSR_CRMD) begin
            r_crmd <= csr_merge(r_crmd, csr_wmask, csr_wvalue, CRMD_WMASK);
        end else if (w_wr && csr_num == CSR_PRMD) begin
            r_prmd <= csr_merge(r_prmd, csr_wmask, csr_wvalue, PRMD_WMASK);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ecfg   <= '0;
            r_eentry <= '0;
        end else if (w_wr && csr_num == CSR_ECFG) begin
            r_ecfg <= csr_merge(r_ecfg, csr_wmask, csr_wvalue, ECFG_WMASK);
        end else if (w_wr && csr_num == CSR_EENTRY) begin
            r_eentry <= csr_merge(r_eentry, csr_wmask, csr_wvalue,
                                  EENTRY_WMASK);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_sw <= '0;
            r_is_hw <= '0;
            r_is_ti <= 1'b0;
            r_ecode <= '0;
            r_esub  <= '0;
            r_era   <= '0;
        end else begin
            r_is_hw <= hw_int;
            // Expiry beats a same-cycle TICLR clear.
            if (w_expire) begin
                r_is_ti <= 1'b1;
            end else if (w_ticlr) begin
                r_is_ti <= 1'b0;
            end
            if (w_exc) begin
                r_era   <= wb_pc;
                r_ecode <= wb_ecode;
                r_esub  <= wb_esubcode;
            end else if (w_wr && csr_num == CSR_ESTAT) begin
                r_is_sw <= csr_merge(32'(r_is_sw), csr_wmask, csr_wvalue,
                                     ESTAT_WMASK) >> 0 == 0 ? 2'b00 :
                           2'(csr_merge(32'(r_is_sw), csr_wmask,
                                        csr_wvalue, ESTAT_WMASK));
            end else if (w_wr && csr_num == CSR_ERA) begin
                r_era <= csr_merge(r_era, csr_wmask, csr_wvalue, FULL_WMASK);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                r_save[i] <= '0;
            end
        end else if (w_wr && csr_num[13:2] == CSR_SAVE0[13:2]) begin
            r_save[csr_num[1:0]] <= csr_merge(r_save[csr_num[1:0]],
                                              csr_wmask, csr_wvalue,
                                              FULL_WMASK);
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        case (csr_num)
            CSR_CRMD:   w_rdata = r_crmd;
            CSR_PRMD:   w_rdata = r_prmd;
            CSR_ECFG:   w_rdata = r_ecfg;
            CSR_ESTAT:  w_rdata = w_estat;
            CSR_ERA:    w_rdata = r_era;
            CSR_EENTRY: w_rdata = r_eentry;
            CSR_SAVE0:  w_rdata = r_save[0];
            CSR_SAVE1:  w_rdata = r_save[1];
            CSR_SAVE2:  w_rdata = r_save[2];
            CSR_SAVE3:  w_rdata = r_save[3];
            CSR_TCFG:   w_rdata = w_tcfg;
            CSR_TVAL:   w_rdata = w_tval;
            default:    w_rdata = 32'h0;
        endcase
    end

    assign csr_rvalue = csr_re ? w_rdata : 32'h0;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: field-mask table, directed
// exception/ERTN/timer sequences and randomized traffic vs a cycle model.
module tb_exc_ctrl;
    import csr_defs::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [7:0]  hw_int;
    logic        has_int;
    logic        flush;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    exc_ctrl #(.TIMER_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .csr_re      (csr_re),
        .csr_num     (csr_num),
        .csr_rvalue  (csr_rvalue),
        .csr_we      (csr_we),
        .csr_wmask   (csr_wmask),
        .csr_wvalue  (csr_wvalue),
        .wb_ex       (wb_ex),
        .ertn_flush  (ertn_flush),
        .wb_ecode    (wb_ecode),
        .wb_esubcode (wb_esubcode),
        .wb_pc       (wb_pc),
        .hw_int      (hw_int),
        .has_int     (has_int),
        .flush       (flush),
        .redirect_pc (redirect_pc)
    );

    int errs = 0;
    int checks = 0;

    // Architectural model state.
    logic [31:0] m_crmd, m_prmd, m_ecfg, m_era, m_eentry;
    logic [31:0] m_tcfg, m_tval;
    logic [31:0] m_save [4];
    logic [1:0]  m_is_sw;
    logic [7:0]  m_hw;
    logic        m_ti;
    logic [5:0]  m_ecode;
    logic [8:0]  m_esub;
    logic        m_flush;

    typedef struct {
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    logic [13:0] nums [16] = '{
        CSR_CRMD, CSR_PRMD, CSR_ECFG, CSR_ESTAT, CSR_ERA, CSR_EENTRY,
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3, CSR_TCFG, CSR_TVAL,
        CSR_TICLR, 14'h007, 14'h003, CSR_TCFG
    };

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [13:0] n);
        case (n)
            CSR_CRMD:   return m_crmd;
            CSR_PRMD:   return m_prmd;
            CSR_ECFG:   return m_ecfg;
            CSR_ESTAT:  return {1'b0, m_esub, m_ecode, 4'b0, m_ti, 1'b0,
                                m_hw, m_is_sw};
            CSR_ERA:    return m_era;
            CSR_EENTRY: return m_eentry;
            CSR_SAVE0:  return m_save[0];
            CSR_SAVE1:  return m_save[1];
            CSR_SAVE2:  return m_save[2];
            CSR_SAVE3:  return m_save[3];
            CSR_TCFG:   return m_tcfg;
            CSR_TVAL:   return m_tval;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic logic m_has_int();
        logic [31:0] e;
        e = m_read(CSR_ESTAT);
        return m_crmd[2] && ((e[12:0] & m_ecfg[12:0]) != 13'h0);
    endfunction

    task automatic m_reset();
        m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_era = 0; m_eentry = 0;
        m_tcfg = 0; m_tval = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) m_save[i] = 0;
        m_is_sw = 0; m_hw = 0; m_ti = 0; m_ecode = 0; m_esub = 0;
        m_flush = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic m_update();
        logic ex, er, wr, fire;
        logic [31:0] nv, wv, old_crmd;
        ex = !m_flush && wb_ex;
        er = !m_flush && !wb_ex && ertn_flush;
        wr = !m_flush && csr_we && !wb_ex && !ertn_flush;
        nv = (m_read(csr_num) & ~csr_wmask) | (csr_wvalue & csr_wmask);
        wv = csr_wvalue & csr_wmask;
        fire = 1'b0;
        if (wr && csr_num == CSR_TCFG) begin
            m_tcfg = nv;
            m_tval = {nv[31:2], 2'b00};
        end else if (m_tcfg[0]) begin
            if (m_tval == 0) begin
                if (m_tcfg[1]) m_tval = {m_tcfg[31:2], 2'b00};
                else begin m_tval = 32'hFFFF_FFFF; m_tcfg[0] = 1'b0; end
            end else begin
                fire = (m_tval == 1);
                m_tval = m_tval - 1;
            end
        end
        if (fire) m_ti = 1'b1;
        else if (wr && csr_num == CSR_TICLR && wv[0]) m_ti = 1'b0;
        old_crmd = m_crmd;
        if (ex) begin
            m_prmd = {29'b0, old_crmd[2:0]};
            m_crmd = {old_crmd[31:3], 3'b000};
            m_era = wb_pc; m_ecode = wb_ecode; m_esub = wb_esubcode;
        end else if (er) begin
            m_crmd = {old_crmd[31:3], m_prmd[2:0]};
        end else if (wr) begin
            case (csr_num)
                CSR_CRMD:   m_crmd = nv & 32'hF;
                CSR_PRMD:   m_prmd = nv & 32'h7;
                CSR_ECFG:   m_ecfg = nv & 32'h1BFF;
                CSR_ESTAT:  m_is_sw = nv[1:0];
                CSR_ERA:    m_era = nv;
                CSR_EENTRY: m_eentry = nv & 32'hFFFF_FFC0;
                CSR_SAVE0:  m_save[0] = nv;
                CSR_SAVE1:  m_save[1] = nv;
                CSR_SAVE2:  m_save[2] = nv;
                CSR_SAVE3:  m_save[3] = nv;
                default: ;
            endcase
        end
        m_hw = hw_int;
        m_flush = ex || er;
    endtask

    // Called at a falling edge with inputs applied.
    task automatic tick();
        logic ex_ok, er_ok;
        #1;
        ex_ok = !m_flush && wb_ex;
        er_ok = !m_flush && !wb_ex && ertn_flush;
        check("flush", 32'(flush), 32'(ex_ok || er_ok));
        if (ex_ok || er_ok)
            check("redirect_pc", redirect_pc, ex_ok ? m_eentry : m_era);
        check("csr_rvalue", csr_rvalue, csr_re ? m_read(csr_num) : 32'h0);
        check("has_int", 32'(has_int), 32'(m_has_int()));
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic idle();
        csr_re = 1'b1; csr_num = CSR_CRMD; csr_we = 1'b0;
        csr_wmask = 0; csr_wvalue = 0; wb_ex = 1'b0; ertn_flush = 1'b0;
        wb_ecode = 0; wb_esubcode = 0; wb_pc = 0;
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] m,
                      input logic [31:0] v);
        idle();
        csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v;
        tick();
    endtask

    task automatic rd_check(input string nm, input logic [13:0] n,
                            input logic [31:0] e);
        idle();
        csr_num = n;
        #1;
        check(nm, csr_rvalue, e);
        tick();
    endtask

    task automatic do_reset();
        idle();
        hw_int = 0;
        resetn = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{CSR_TVAL,   32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF};
        tbl[1]  = '{CSR_CRMD,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
        tbl[2]  = '{CSR_CRMD,   32'h0000_0004, 32'h0,         32'h0000_000B};
        tbl[3]  = '{CSR_PRMD,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
        tbl[4]  = '{CSR_ECFG,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF};
        tbl[5]  = '{CSR_ESTAT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        tbl[6]  = '{CSR_ESTAT,  32'h0000_0001, 32'h0,         32'h0000_0002};
        tbl[7]  = '{CSR_ERA,    32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
        tbl[8]  = '{CSR_ERA,    32'hFFFF_0000, 32'h0,         32'h0000_5678};
        tbl[9]  = '{CSR_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFC0};
        tbl[10] = '{CSR_SAVE0,  32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        tbl[11] = '{CSR_SAVE3,  32'h00FF_00FF, 32'h5A5A_0001, 32'h005A_0001};
        tbl[12] = '{CSR_TICLR,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0};
        tbl[13] = '{14'h007,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        tbl[14] = '{CSR_TCFG,   32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_0100};
        tbl[15] = '{CSR_TVAL,   32'h0,         32'h0,         32'h0000_0100};

        idle();
        hw_int = 0;
        resetn = 1'b0;
        m_reset();
        @(negedge clk);
        csr_num = CSR_CRMD; #1;
        check("reset_crmd", csr_rvalue, 32'h8);
        csr_num = CSR_TVAL; #1;
        check("reset_tval", csr_rvalue, 32'hFFFF_FFFF);
        check("reset_flush", 32'(flush), 32'h0);
        check("reset_has_int", 32'(has_int), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            wr(tbl[i].num, tbl[i].mask, tbl[i].val);
            rd_check($sformatf("tbl%0d", i), tbl[i].num, tbl[i].exp);
        end

        // Exception entry.
        do_reset();
        wr(CSR_EENTRY, 32'hFFFF_FFFF, 32'h1C00_8000);
        idle();
        wb_ex = 1'b1; wb_ecode = ECODE_SYS; wb_pc = 32'h1C00_0100;
        #1;
        check("exc_flush", 32'(flush), 32'h1);
        check("exc_redirect", redirect_pc, 32'h1C00_8000);
        tick();
        rd_check("exc_era", CSR_ERA, 32'h1C00_0100);
        rd_check("exc_estat", CSR_ESTAT, 32'h000B_0000);
        rd_check("exc_crmd", CSR_CRMD, 32'h0000_0008);

        // Exception then ERTN two cycles later.
        do_reset();
        wr(CSR_CRMD, 32'h4, 32'h4);
        idle(); wb_ex = 1'b1; wb_pc = 32'h0000_0100; tick();
        idle(); tick();
        idle(); ertn_flush = 1'b1;
        #1;
        check("ertn_flush", 32'(flush), 32'h1);
        check("ertn_redirect", redirect_pc, 32'h0000_0100);
        tick();
        rd_check("ertn_crmd", CSR_CRMD, 32'h0000_000C);
        rd_check("ertn_prmd", CSR_PRMD, 32'h0000_0004);

        // Back-to-back exceptions: the second is wrong-path.
        do_reset();
        idle(); wb_ex = 1'b1; wb_pc = 32'h200; tick();
        idle(); wb_ex = 1'b1; wb_pc = 32'h300;
        #1;
        check("dbl_flush", 32'(flush), 32'h0);
        tick();
        rd_check("dbl_era", CSR_ERA, 32'h200);

        // Periodic timer with interrupt.
        do_reset();
        wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h800);
        wr(CSR_CRMD, 32'h4, 32'h4);
        wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
        repeat (7) begin idle(); tick(); end
        rd_check("tmr_pre", CSR_ESTAT, 32'h0);
        #1;
        check("tmr_has_int", 32'(has_int), 32'h1);
        rd_check("tmr_set", CSR_ESTAT, 32'h800);
        wr(CSR_TICLR, 32'hFFFF_FFFF, 32'h1);
        rd_check("tmr_clr", CSR_ESTAT, 32'h0);
        repeat (5) begin idle(); tick(); end
        rd_check("tmr_pre2", CSR_ESTAT, 32'h0);
        rd_check("tmr_set2", CSR_ESTAT, 32'h800);

        // One-shot expiry coinciding with TICLR.
        do_reset();
        wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
        repeat (3) begin idle(); tick(); end
        wr(CSR_TICLR, 32'hFFFF_FFFF, 32'h1);
        rd_check("os_ti", CSR_ESTAT, 32'h800);
        rd_check("os_tval", CSR_TVAL, 32'hFFFF_FFFF);
        rd_check("os_tcfg", CSR_TCFG, 32'h0000_0004);

        // TCFG rewrite coinciding with expiry suppresses IS.
        do_reset();
        wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0007);
        repeat (3) begin idle(); tick(); end
        wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0007);
        rd_check("tw_ti", CSR_ESTAT, 32'h0);
        rd_check("tw_tval", CSR_TVAL, 32'h3);

        // Writes suppressed by exception and by FLUSH.
        do_reset();
        wr(CSR_SAVE0, 32'hFFFF_FFFF, 32'h1111_1111);
        idle();
        csr_we = 1'b1; csr_num = CSR_SAVE0;
        csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h2222_2222;
        wb_ex = 1'b1;
        tick();
        wr(CSR_SAVE1, 32'hFFFF_FFFF, 32'h3333_3333);
        rd_check("sup_save0", CSR_SAVE0, 32'h1111_1111);
        rd_check("sup_save1", CSR_SAVE1, 32'h0);

        // hw_int reaches has_int one cycle later.
        do_reset();
        wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h4);
        wr(CSR_CRMD, 32'h4, 32'h4);
        idle(); hw_int = 8'h01;
        #1;
        check("hw_int_d0", 32'(has_int), 32'h0);
        tick();
        #1;
        check("hw_int_d1", 32'(has_int), 32'h1);
        hw_int = 8'h00;

        // Reset in FLUSH returns to IDLE.
        do_reset();
        idle(); wb_ex = 1'b1; wb_pc = 32'h40; tick();
        idle();
        resetn = 1'b0;
        m_reset();
        @(negedge clk);
        resetn = 1'b1;
        idle(); wb_ex = 1'b1; wb_pc = 32'h80;
        #1;
        check("rst_flush", 32'(flush), 32'h1);
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            csr_re = ($urandom_range(0, 7) != 0);
            csr_num = nums[$urandom_range(0, 15)];
            if ($urandom_range(0, 3) == 0) begin
                csr_we = 1'b1;
                csr_wmask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF
                                                        : $urandom;
                csr_wvalue = $urandom;
                if (csr_num == CSR_TCFG) begin
                    csr_wmask = 32'hFFFF_FFFF;
                    csr_wvalue = 32'($urandom_range(0, 31));
                end
            end
            wb_ex = ($urandom_range(0, 15) == 0);
            ertn_flush = ($urandom_range(0, 15) == 0);
            wb_ecode = 6'($urandom);
            wb_esubcode = 9'($urandom);
            wb_pc = $urandom;
            if ($urandom_range(0, 31) == 0) hw_int = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
